// File: rtl/pkt_ch_parser.sv
// Packet parser for heartbeat / CH-advertisement frames fetched from packet memory.
// Optional trailer checksum (XOR of all preceding bytes) enabled by `define PKT_CHECKSUM_EN.
module pkt_ch_parser (
  input  logic        clk,
  input  logic        nrst,
  input  logic        start,
  input  logic [10:0] base_addr,
  output logic [10:0] mem_addr,
  output logic        mem_ren,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        HB_reset,
  output logic [15:0] HB_CHlimit,
  output logic        en_KCH,
  output logic [15:0] fCH_ID,
  output logic [15:0] fCH_Hops,
  output logic [15:0] fCH_QValue
);

`ifdef PKT_CHECKSUM_EN
  localparam logic [3:0] TRAILER = 4'd1;
`else
  localparam logic [3:0] TRAILER = 4'd0;
`endif
  localparam logic [7:0] TYPE_HB  = 8'h01;
  localparam logic [7:0] TYPE_ADV = 8'h02;
  localparam logic [3:0] LEN_HB   = 4'd3 + TRAILER;
  localparam logic [3:0] LEN_ADV  = 4'd7 + TRAILER;

  typedef enum logic [1:0] {IDLE, FETCH, COMMIT, REJECT} state_t;

  state_t      state, state_nxt;
  logic [10:0] base_q;
  logic [3:0]  cnt;
  logic [7:0]  type_q;
  logic [47:0] shreg;
  logic [7:0]  csum;

  logic [3:0]  pkt_len;
  logic [3:0]  byte_idx;
  logic        capture;
  logic        last_byte;
  logic        type_bad;
  logic        sum_bad;
  logic        commit_now;
  logic [47:0] payload;

  // cnt counts cycles since the start edge: address cnt is issued in cycle cnt,
  // and the byte requested one cycle earlier (index cnt-1) arrives on mem_rdata.
  always_comb begin
    pkt_len   = (type_q == TYPE_ADV) ? LEN_ADV : LEN_HB;
    capture   = (state == FETCH) && (cnt != 4'd0);
    byte_idx  = cnt - 4'd1;
    type_bad  = capture && (byte_idx == 4'd0) &&
                (mem_rdata != TYPE_HB) && (mem_rdata != TYPE_ADV);
    last_byte = capture && (byte_idx != 4'd0) && (byte_idx == pkt_len - 4'd1);
`ifdef PKT_CHECKSUM_EN
    sum_bad   = last_byte && (csum != mem_rdata);
    payload   = shreg;
`else
    sum_bad   = 1'b0;
    payload   = {shreg[39:0], mem_rdata};
`endif
    commit_now = last_byte && !sum_bad;
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH: begin
        if (type_bad || sum_bad) state_nxt = REJECT;
        else if (commit_now)     state_nxt = COMMIT;
      end
      COMMIT:  state_nxt = IDLE;
      REJECT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Type byte is guaranteed captured before pkt_len can matter (every packet is >= 3 bytes).
  always_comb begin
    busy     = (state != IDLE);
    mem_ren  = (state == FETCH) && (cnt < pkt_len);
    mem_addr = base_q + {7'd0, cnt};
    done     = (state == COMMIT);
    err      = (state == REJECT);
    HB_reset = done && (type_q == TYPE_HB);
    en_KCH   = done && (type_q == TYPE_ADV);
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      base_q <= 11'd0;
      cnt    <= 4'd0;
      type_q <= 8'd0;
      shreg  <= 48'd0;
      csum   <= 8'd0;
    end else begin
      if (state == FETCH) begin
        cnt <= cnt + 4'd1;
        if (capture) begin
          shreg <= {shreg[39:0], mem_rdata};
          csum  <= csum ^ mem_rdata;
          if (byte_idx == 4'd0) type_q <= mem_rdata;
        end
      end else begin
        cnt <= 4'd0;
        if (state == IDLE && start) begin
          base_q <= base_addr;
          csum   <= 8'd0;
        end
      end
    end
  end

  // Visible fields only move at the commit edge; the other packet type's fields hold.
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      HB_CHlimit <= 16'h0000;
      fCH_ID     <= 16'h0000;
      fCH_Hops   <= 16'hFFFF;
      fCH_QValue <= 16'h0000;
    end else if (commit_now) begin
      if (type_q == TYPE_HB) HB_CHlimit <= payload[15:0];
      else {fCH_ID, fCH_Hops, fCH_QValue} <= payload;
    end
  end

endmodule

// File: tb/tb_pkt_ch_parser.sv
// Scoreboard bench for pkt_ch_parser: directed frames plus randomized packets checked
// against a byte-level reference model. Honors `define PKT_CHECKSUM_EN like the RTL.
module tb_pkt_ch_parser;

`ifdef PKT_CHECKSUM_EN
  localparam int TRL = 1;
`else
  localparam int TRL = 0;
`endif

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic [10:0] base_addr;
  logic [10:0] mem_addr;
  logic        mem_ren;
  logic [7:0]  mem_rdata;
  logic        busy, done, err, HB_reset, en_KCH;
  logic [15:0] HB_CHlimit, fCH_ID, fCH_Hops, fCH_QValue;

  pkt_ch_parser dut (
    .clk(clk), .nrst(nrst), .start(start), .base_addr(base_addr),
    .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .err(err), .HB_reset(HB_reset), .HB_CHlimit(HB_CHlimit),
    .en_KCH(en_KCH), .fCH_ID(fCH_ID), .fCH_Hops(fCH_Hops), .fCH_QValue(fCH_QValue)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:2047];
  always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;   // 1 heartbeat, 2 advertisement, 3 reject
    int          cyc;
    logic [15:0] hb, id, hops, q;
  } exp_t;

  exp_t        exp_q[$];
  logic [10:0] addr_q[$];
  logic [7:0]  pkt[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] m_hb = 16'h0000, m_id = 16'h0000, m_hops = 16'hFFFF, m_q = 16'h0000;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic reportFail(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got 0x%0h expected nothing (t=%0t)", name, act, $time);
  endtask

  // Monitor: every read address and every output pulse is matched against the scoreboard.
  exp_t e;
  int   act_kind;
  always @(negedge clk) begin
    if (!nrst) begin
      if (mem_ren) begin
        if (addr_q.size() == 0) reportFail("unexpected_read", {53'd0, mem_addr});
        else checkOutput("mem_addr", {53'd0, mem_addr}, {53'd0, addr_q.pop_front()});
      end
      if (done || err || HB_reset || en_KCH) begin
        act_kind = err ? 3 : (HB_reset ? 1 : (en_KCH ? 2 : 0));
        checkOutput("pulse_excl",
                    {63'd0, (err && (done || HB_reset || en_KCH)) || (HB_reset && en_KCH) ||
                            (done != (HB_reset || en_KCH))}, 64'd0);
        if (exp_q.size() == 0) reportFail("unexpected_pulse", act_kind);
        else begin
          e = exp_q.pop_front();
          checkOutput("pulse_kind", act_kind, e.kind);
          checkOutput("pulse_cycle", cyc, e.cyc);
          checkOutput("HB_CHlimit", {48'd0, HB_CHlimit}, {48'd0, e.hb});
          checkOutput("fCH_ID", {48'd0, fCH_ID}, {48'd0, e.id});
          checkOutput("fCH_Hops", {48'd0, fCH_Hops}, {48'd0, e.hops});
          checkOutput("fCH_QValue", {48'd0, fCH_QValue}, {48'd0, e.q});
        end
      end
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ctrl"}, {58'd0, busy, done, err, HB_reset, en_KCH, mem_ren}, 64'd0);
    checkOutput({tag, "_mem_addr"}, {53'd0, mem_addr}, 64'd0);
    checkOutput({tag, "_fields"}, {HB_CHlimit, fCH_ID, fCH_Hops, fCH_QValue},
                {16'h0000, 16'h0000, 16'hFFFF, 16'h0000});
  endtask

  // Build a frame in pkt: kind 0 heartbeat, 1 advertisement, 2 bad type.
  task automatic buildPacket(input int kind, input bit corrupt);
    logic [7:0] x;
    int n;
    pkt.delete();
    if (kind == 0) pkt.push_back(8'h01);
    else if (kind == 1) pkt.push_back(8'h02);
    else begin
      x = 8'($urandom_range(0, 255));
      while (x == 8'h01 || x == 8'h02) x = 8'($urandom_range(0, 255));
      pkt.push_back(x);
    end
    n = (kind == 0) ? 3 : 7;
    for (int i = 1; i < n; i++) pkt.push_back(8'($urandom_range(0, 255)));
    if (TRL == 1) begin
      x = 8'h00;
      foreach (pkt[i]) x ^= pkt[i];
      pkt.push_back(corrupt ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
    end
  endtask

  // Reference model: derive reads, pulse and fields from the frame bytes, then drive start.
  task automatic applyStimulus(input logic [10:0] base, input bit mid_start, input int reset_at);
    exp_t ex;
    int   n, k;
    logic [7:0] x;
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    if (busy) reportFail("idle_timeout", 1);
    for (int i = 0; i < pkt.size(); i++) mem[11'(base + 11'(i))] = pkt[i];
    k = cyc;
    if (pkt[0] != 8'h01 && pkt[0] != 8'h02) begin
      ex.kind = 3;
      ex.cyc  = k + 3;
      addr_q.push_back(base);
      addr_q.push_back(11'(base + 11'd1));
    end else begin
      n = ((pkt[0] == 8'h01) ? 3 : 7) + TRL;
      for (int i = 0; i < n; i++) addr_q.push_back(11'(base + 11'(i)));
      x = 8'h00;
      for (int i = 0; i < n - 1; i++) x ^= pkt[i];
      ex.cyc = k + n + 2;
      if (TRL == 1 && x != pkt[n-1]) ex.kind = 3;
      else begin
        ex.kind = pkt[0];
        if (pkt[0] == 8'h01) m_hb = {pkt[1], pkt[2]};
        else begin
          m_id   = {pkt[1], pkt[2]};
          m_hops = {pkt[3], pkt[4]};
          m_q    = {pkt[5], pkt[6]};
        end
      end
    end
    ex.hb = m_hb; ex.id = m_id; ex.hops = m_hops; ex.q = m_q;
    exp_q.push_back(ex);
    base_addr = base;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (reset_at > 0) begin
      repeat (reset_at) @(posedge clk);
      #1 nrst = 1'b1;
      #1 checkResetValues("mid_reset");
      exp_q.delete();
      addr_q.delete();
      m_hb = 16'h0000; m_id = 16'h0000; m_hops = 16'hFFFF; m_q = 16'h0000;
      @(negedge clk);
      @(negedge clk);
      nrst = 1'b0;
      repeat (20) @(negedge clk);
      return;
    end
    if (mid_start) begin
      repeat (2) @(negedge clk);
      base_addr = 11'($urandom_range(0, 2047));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 60 && (exp_q.size() != 0 || addr_q.size() != 0); i++) @(negedge clk);
    if (exp_q.size() != 0 || addr_q.size() != 0) begin
      reportFail("response_timeout", exp_q.size());
      exp_q.delete();
      addr_q.delete();
    end
  endtask

  initial begin
    nrst = 1'b1;
    start = 1'b0;
    base_addr = 11'd0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom_range(0, 255));
    #12 checkResetValues("reset");
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);

    pkt = '{8'h02, 8'h00, 8'h17, 8'h00, 8'h02, 8'h30, 8'h00};
    if (TRL == 1) pkt.push_back(8'h27);
    applyStimulus(11'h010, 1'b0, 0);
    checkOutput("adv_fields", {fCH_ID, fCH_Hops, fCH_QValue}, {16'd23, 16'd2, 16'h3000});

    pkt = '{8'h01, 8'h00, 8'h03};
    if (TRL == 1) pkt.push_back(8'h02);
    applyStimulus(11'h100, 1'b0, 0);
    checkOutput("hb_fields", {HB_CHlimit, fCH_ID, fCH_Hops, fCH_QValue},
                {16'd3, 16'd23, 16'd2, 16'h3000});

    pkt = '{8'h7F, 8'h11, 8'h22, 8'h33};
    applyStimulus(11'h200, 1'b0, 0);
    @(negedge clk);
    checkOutput("busy_after_err", {63'd0, busy}, 64'd0);

    buildPacket(1, 1'b0);
    applyStimulus(11'h7FE, 1'b1, 0);

    buildPacket(1, 1'b0);
    applyStimulus(11'h300, 1'b0, 4);

    if (TRL == 1) begin
      buildPacket(1, 1'b1);
      applyStimulus(11'h040, 1'b0, 0);
      checkOutput("corrupt_hold", {fCH_ID, fCH_Hops, fCH_QValue}, {m_id, m_hops, m_q});
    end

    for (int t = 0; t < 40; t++) begin
      int kind;
      logic [10:0] b;
      kind = ($urandom_range(0, 9) < 2) ? 2 : int'($urandom_range(0, 1));
      buildPacket(kind, (TRL == 1) && ($urandom_range(0, 4) == 0));
      b = ($urandom_range(0, 3) == 0) ? 11'(2043 + $urandom_range(0, 4))
                                      : 11'($urandom_range(0, 2047));
      applyStimulus(b, (kind != 2) && ($urandom_range(0, 2) == 0), 0);
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pkt_ch_parser.md
PKT_CH_PARSER -- requirements
Module: pkt_ch_parser

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
REQ-002 The clock and reset ports SHALL be:
- clk  in  1  rising-edge clock.
- nrst  in  1  asynchronous reset, active-high.
REQ-003 The remaining ports SHALL be:
- start  in  1  parse request, sampled only in IDLE.
- base_addr  in  11  byte address of the packet's first byte.
- mem_addr  out  11  packet memory read address.
- mem_ren  out  1  memory read enable.
- mem_rdata  in  8  memory data, valid the cycle after mem_addr/mem_ren.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse, packet accepted.
- err  out  1  one-cycle pulse, packet rejected.
- HB_reset  out  1  one-cycle pulse, heartbeat accepted.
- HB_CHlimit  out  16  CH limit from the last accepted heartbeat.
- en_KCH  out  1  one-cycle pulse, CH advertisement accepted.
- fCH_ID  out  16  advertised CH ID.
- fCH_Hops  out  16  advertised hop count.
- fCH_QValue  out  16  advertised Q-value.

Function
REQ-004 Packet formats SHALL be big-endian, with byte 0 as the type byte:
- Heartbeat, N=3 bytes: 0x01, CHlimit hi, CHlimit lo.
- CH advertisement, N=7 bytes: 0x02, ID hi/lo, Hops hi/lo, QValue hi/lo.
REQ-005 The FSM SHALL use the states IDLE, FETCH, COMMIT and REJECT.
- IDLE->FETCH: start=1 sampled at edge E0.
- FETCH->COMMIT: last byte captured.
- FETCH->REJECT: bad type or checksum.
- COMMIT/REJECT->IDLE: after one cycle.
REQ-006 From E0, mem_ren=1 and mem_addr=base_addr+i SHALL be driven in consecutive cycles for i=0..N-1; byte i SHALL be captured at edge E0+i+1.
REQ-007 Address arithmetic SHALL be 11-bit modulo 2048 (0x7FF+1 wraps to 0x000).
REQ-008 The type byte SHALL be decoded at capture; any type other than 0x01/0x02 SHALL go to REJECT, and err SHALL be high in the cycle after edge E0+2.
REQ-009 In COMMIT, visible from edge E0+N+1 for one cycle:
- done=1.
- Heartbeat: HB_reset=1, HB_CHlimit updated.
- CH advertisement: en_KCH=1, fCH_ID/fCH_Hops/fCH_QValue updated.
REQ-010 Output fields SHALL change only at the COMMIT edge; partially fetched bytes SHALL be held internally and never exposed.
REQ-011 Outputs of the other packet type SHALL hold their values across a commit.
REQ-012 start while busy=1 SHALL be ignored and not queued.
REQ-013 start in the cycle the FSM returns to IDLE SHALL NOT be sampled; it is sampled from the first cycle in IDLE.
REQ-014 mem_ren SHALL be 0 in IDLE, COMMIT and REJECT.
REQ-015 done, err, HB_reset and en_KCH SHALL be mutually exclusive and never high for two consecutive cycles.

Reset
REQ-016 nrst=1 SHALL force IDLE immediately, with no clock required.
REQ-017 Reset values SHALL be:
- busy=0, done=0, err=0, HB_reset=0, en_KCH=0, mem_ren=0.
- mem_addr=0.
- HB_CHlimit=0x0000.
- fCH_ID=0x0000, fCH_Hops=0xFFFF, fCH_QValue=0x0000.
REQ-018 Reset during FETCH SHALL abort the packet: no pulse is produced, and all fields take their reset values.

Configuration
REQ-019 The macro PKT_CHECKSUM_EN SHALL select trailer checking.
- Defined: every packet carries one trailer byte (N=4 heartbeat, N=8 advertisement) equal to the XOR of all preceding bytes.
- Mismatch: REJECT, err pulse at edge E0+N+1, no field update.
- Undefined: no trailer byte is fetched and N is per REQ-004.

Verification
REQ-020 CH advertisement: memory at 0x010 = 02 00 17 00 02 30 00, start at E0 -> en_KCH and done high one cycle after E0+8; fCH_ID=23, fCH_Hops=2, fCH_QValue=0x3000. With PKT_CHECKSUM_EN, trailer 0x27 appended and the pulse moves to E0+9.
REQ-021 Heartbeat: bytes 01 00 03 -> HB_reset pulse after E0+4; HB_CHlimit=3; fCH_* unchanged.
REQ-022 Bad type: type 0x7F -> err pulse after E0+2; no other pulse; mem_ren stops; busy=0 after err.
REQ-023 Wrap and busy: advertisement at base 0x7FE -> mem_addr sequence 7FE, 7FF, 000..004; a start pulse mid-fetch is ignored and exactly one en_KCH occurs.
REQ-024 Reset mid-operation: nrst asserted at E0+4 of an advertisement -> outputs immediately at reset values (fCH_Hops=0xFFFF); no en_KCH after release.
REQ-025 PKT_CHECKSUM_EN defined, corrupted trailer -> err at E0+9; fields hold their previous values.
